// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
// Request sequencer placed directly in front of the CPU stack array. It
// accepts push/pop requests over a valid/ready handshake and drives the
// stack opcode/data lines for exactly one cycle per operation. Popped words
// are captured one cycle after the pop is issued and returned on a response
// strobe. Occupancy is tracked here so that overflow, underflow and illegal
// opcodes are refused before they reach the stack.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE only)
//   req_op     in   00 push reg, 01 push imm, 10 pop, 11 illegal
//   req_data   in   value to push (ignored for pop)
//   stk_opcode out  1101 push reg, 1110 push imm, 1111 pop, 0000 idle
//   stk_data   out  stack data input
//   stk_q      in   stack data output
//   rsp_valid  out  one-cycle strobe, rsp_data holds the popped value
//   rsp_data   out  last popped value
//   depth      out  current occupancy, 0..DEPTH
//   full       out  depth == DEPTH
//   empty      out  depth == 0
//   err        out  one-cycle pulse on a refused request
//   err_code   out  01 overflow, 10 underflow, 11 illegal op
//
// State table
//   state     | meaning
//   S_IDLE    | waiting for a request, req_ready high
//   S_ISSUE   | stk_opcode/stk_data presented to the stack for this cycle
//   S_CAPTURE | stk_q holds the popped word, registered at the next edge
// ---------------------------------------------------------------------------
module stack_ctrl #(
    parameter int DEPTH = 256,
    parameter int DW    = 8,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [DW-1:0] req_data,
    output logic [3:0]    stk_opcode,
    output logic [DW-1:0] stk_data,
    input  logic [DW-1:0] stk_q,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic [CW-1:0] depth,
    output logic          full,
    output logic          empty,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam logic [CW-1:0] DEPTH_MAX = CW'(DEPTH);

    localparam logic [1:0] REQ_PUSH_REG = 2'b00;
    localparam logic [1:0] REQ_PUSH_IMM = 2'b01;
    localparam logic [1:0] REQ_POP      = 2'b10;
    localparam logic [1:0] REQ_ILLEGAL  = 2'b11;

    localparam logic [3:0] OP_IDLE     = 4'b0000;
    localparam logic [3:0] OP_PUSH_REG = 4'b1101;
    localparam logic [3:0] OP_PUSH_IMM = 4'b1110;
    localparam logic [3:0] OP_POP      = 4'b1111;

    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t state;

    assign req_ready = (state == S_IDLE);
    assign full      = (depth == DEPTH_MAX);
    assign empty     = (depth == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            stk_opcode <= OP_IDLE;
            stk_data   <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            depth      <= '0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            // Both strobes are single-cycle; they are re-raised below only
            // on the edge that produces them.
            err       <= 1'b0;
            rsp_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_op == REQ_ILLEGAL) begin
                            err      <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                        end else if (req_op == REQ_POP && empty) begin
                            err      <= 1'b1;
                            err_code <= ERR_UNDERFLOW;
                        end else if (req_op != REQ_POP && full) begin
                            err      <= 1'b1;
                            err_code <= ERR_OVERFLOW;
                        end else begin
                            case (req_op)
                                REQ_PUSH_REG: stk_opcode <= OP_PUSH_REG;
                                REQ_PUSH_IMM: stk_opcode <= OP_PUSH_IMM;
                                default:      stk_opcode <= OP_POP;
                            endcase
                            stk_data <= (req_op == REQ_POP) ? '0 : req_data;
                            state    <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    // The registered opcode doubles as the record of which
                    // operation is in flight, so no separate flag is kept.
                    stk_opcode <= OP_IDLE;
                    if (stk_opcode == OP_POP) begin
                        depth <= depth - CW'(1);
                        state <= S_CAPTURE;
                    end else begin
                        depth <= depth + CW'(1);
                        state <= S_IDLE;
                    end
                end

                S_CAPTURE: begin
                    rsp_data  <= stk_q;
                    rsp_valid <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    stk_opcode <= OP_IDLE;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;

    localparam int DEPTH = 256;
    localparam int DW    = 8;
    localparam int CW    = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [DW-1:0] req_data;
    logic [3:0]    stk_opcode;
    logic [DW-1:0] stk_data;
    logic [DW-1:0] stk_q;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [CW-1:0] depth;
    logic          full;
    logic          empty;
    logic          err;
    logic [1:0]    err_code;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the logical stack contents, newest at the back.
    logic [DW-1:0] model_q[$];

    // Behavioural stack array driven by the DUT.
    logic [DW-1:0] mem [0:DEPTH-1];
    int            sp;

    stack_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_data   (req_data),
        .stk_opcode (stk_opcode),
        .stk_data   (stk_data),
        .stk_q      (stk_q),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .depth      (depth),
        .full       (full),
        .empty      (empty),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= 0;
            stk_q <= '0;
        end else begin
            case (stk_opcode)
                4'b1101, 4'b1110: begin
                    if (sp < DEPTH) begin
                        mem[sp] <= stk_data;
                        sp      <= sp + 1;
                    end
                end
                4'b1111: begin
                    if (sp > 0) begin
                        stk_q <= mem[sp-1];
                        sp    <= sp - 1;
                    end else begin
                        stk_q <= 8'hEE;
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [3:0] exp_opcode(input logic [1:0] op);
        case (op)
            2'b00:   return 4'b1101;
            2'b01:   return 4'b1110;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Presents one request, returns #1 after the accepting edge with the
    // request inputs scrambled so that late changes are exercised.
    task automatic send(input logic [1:0] op, input logic [DW-1:0] d);
        int w = 0;
        while (!req_ready && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_ready_timeout: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_data  = DW'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'($urandom);
            req_op    = 2'($urandom);
            req_data  = DW'($urandom);
            #7;
        end
        n_checks++;
        if ({stk_opcode, depth, empty, req_ready, rsp_valid, err, err_code, rsp_data, stk_data}
            !== {4'b0000, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_values: op=%b depth=%0d empty=%b rdy=%b rv=%b err=%b code=%b rd=%h sd=%h required 0000/0/1/1/0/0/00/00/00",
                     stk_opcode, depth, empty, req_ready, rsp_valid, err, err_code, rsp_data, stk_data);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (stk_opcode !== 4'b0000 || depth !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_quiet: op=%b depth=%0d required 0000 depth 0", stk_opcode, depth);
            end
        end
        model_q.delete();
    endtask

    task automatic test_order();
        logic [1:0] ops [4];
        logic [7:0] dat [4];
        logic [3:0] eop [4];
        int         edep[4];
        ops = '{2'b00, 2'b01, 2'b10, 2'b10};
        dat = '{8'hA5, 8'h3C, 8'h00, 8'h00};
        eop = '{4'b1101, 4'b1110, 4'b1111, 4'b1111};
        edep = '{1, 2, 1, 0};
        for (int i = 0; i < 4; i++) begin
            send(ops[i], dat[i]);
            n_checks++;
            if (stk_opcode !== eop[i] || stk_data !== dat[i]) begin
                n_fail++;
                $display("FAIL order_issue[%0d]: op=%b data=%h required %b %h", i, stk_opcode, stk_data, eop[i], dat[i]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (stk_opcode !== 4'b0000 || depth !== 9'(edep[i])) begin
                n_fail++;
                $display("FAIL order_after[%0d]: op=%b depth=%0d required 0000 %0d", i, stk_opcode, depth, edep[i]);
            end
            if (ops[i] == 2'b10) begin
                logic [7:0] exp_v;
                exp_v = model_q[$];
                model_q.pop_back();
                @(posedge clk); #1;
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp_v) begin
                    n_fail++;
                    $display("FAIL order_rsp[%0d]: rv=%b data=%h required 1 %h", i, rsp_valid, rsp_data, exp_v);
                end
            end else begin
                model_q.push_back(dat[i]);
            end
        end
    endtask

    task automatic test_underflow();
        send(2'b10, 8'h99);
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'b10 || stk_opcode !== 4'b0000 || depth !== 9'd0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow: err=%b code=%b op=%b depth=%0d rdy=%b required 1 10 0000 0 1",
                     err, err_code, stk_opcode, depth, req_ready);
        end
        send(2'b00, 8'h5A);
        n_checks++;
        if (err !== 1'b0 || stk_opcode !== 4'b1101 || stk_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL underflow_next_push: err=%b op=%b data=%h required 0 1101 5a", err, stk_opcode, stk_data);
        end
        @(posedge clk); #1;
        model_q.push_back(8'h5A);
    endtask

    task automatic test_illegal_hold();
        int d0;
        d0 = model_q.size();
        send(2'b11, 8'h12);
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'b11 || stk_opcode !== 4'b0000 || depth !== 9'(d0)) begin
            n_fail++;
            $display("FAIL illegal: err=%b code=%b op=%b depth=%0d required 1 11 0000 %0d", err, err_code, stk_opcode, depth, d0);
        end
        send(2'b01, 8'hC7);
        req_data = 8'h18;
        n_checks++;
        if (stk_data !== 8'hC7 || stk_opcode !== 4'b1110 || err !== 1'b0 || err_code !== 2'b11) begin
            n_fail++;
            $display("FAIL hold_data: data=%h op=%b err=%b code=%b required c7 1110 0 11", stk_data, stk_opcode, err, err_code);
        end
        @(posedge clk); #1;
        model_q.push_back(8'hC7);
        send(2'b10, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_q.pop_back();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'hC7) begin
            n_fail++;
            $display("FAIL hold_popback: rv=%b data=%h required 1 c7", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int         r;
            logic [1:0] op;
            logic [7:0] d;
            logic [1:0] ecode;
            r = $urandom_range(0, 8);
            op = (r < 4) ? 2'(r & 1) : (r < 8) ? 2'b10 : 2'b11;
            d  = DW'($urandom);
            if (op == 2'b11)                                 ecode = 2'b11;
            else if (op == 2'b10 && model_q.size() == 0)     ecode = 2'b10;
            else if (op != 2'b10 && model_q.size() == DEPTH) ecode = 2'b01;
            else                                             ecode = 2'b00;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send(op, d);
            if (ecode != 2'b00) begin
                n_checks++;
                if (err !== 1'b1 || err_code !== ecode || stk_opcode !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL rand_refuse[%0d]: err=%b code=%b op=%b required 1 %b 0000", i, err, err_code, stk_opcode, ecode);
                end
                @(posedge clk); #1;
                n_checks++;
                if (err !== 1'b0 || depth !== 9'(model_q.size())) begin
                    n_fail++;
                    $display("FAIL rand_refuse_after[%0d]: err=%b depth=%0d required 0 %0d", i, err, depth, model_q.size());
                end
            end else begin
                logic [7:0] exp_sd;
                exp_sd = (op == 2'b10) ? 8'h00 : d;
                n_checks++;
                if (stk_opcode !== exp_opcode(op) || stk_data !== exp_sd || err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_issue[%0d]: op=%b data=%h err=%b required %b %h 0", i, stk_opcode, stk_data, err, exp_opcode(op), exp_sd);
                end
                if (op == 2'b10) begin
                    logic [7:0] exp_v;
                    exp_v = model_q[$];
                    model_q.pop_back();
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    n_checks++;
                    if (rsp_valid !== 1'b1 || rsp_data !== exp_v) begin
                        n_fail++;
                        $display("FAIL rand_rsp[%0d]: rv=%b data=%h required 1 %h", i, rsp_valid, rsp_data, exp_v);
                    end
                end else begin
                    model_q.push_back(d);
                    @(posedge clk); #1;
                end
                n_checks++;
                if (depth !== 9'(model_q.size()) || full !== (model_q.size() == DEPTH) || empty !== (model_q.size() == 0)) begin
                    n_fail++;
                    $display("FAIL rand_depth[%0d]: depth=%0d full=%b empty=%b required %0d", i, depth, full, empty, model_q.size());
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_v;
        while (model_q.size() < DEPTH) begin
            logic [7:0] d;
            d = DW'($urandom);
            send(2'($urandom_range(0, 1)), d);
            @(posedge clk); #1;
            model_q.push_back(d);
        end
        n_checks++;
        if (full !== 1'b1 || depth !== 9'd256 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_full: full=%b depth=%0d empty=%b required 1 256 0", full, depth, empty);
        end
        send(2'b00, 8'h44);
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'b01 || stk_opcode !== 4'b0000) begin
            n_fail++;
            $display("FAIL overflow_refuse: err=%b code=%b op=%b required 1 01 0000", err, err_code, stk_opcode);
        end
        @(posedge clk); #1;
        n_checks++;
        if (err !== 1'b0 || depth !== 9'd256 || stk_opcode !== 4'b0000) begin
            n_fail++;
            $display("FAIL overflow_after: err=%b depth=%0d op=%b required 0 256 0000", err, depth, stk_opcode);
        end
        exp_v = model_q[$];
        model_q.pop_back();
        send(2'b10, 8'h00);
        @(posedge clk); #1;
        n_checks++;
        if (full !== 1'b0 || depth !== 9'd255) begin
            n_fail++;
            $display("FAIL overflow_pop_depth: full=%b depth=%0d required 0 255", full, depth);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_v) begin
            n_fail++;
            $display("FAIL overflow_pop_data: rv=%b data=%h required 1 %h", rsp_valid, rsp_data, exp_v);
        end
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        send(2'b00, 8'h77);
        @(posedge clk); #1;
        model_q.push_back(8'h77);
        send(2'b10, 8'h00);
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || depth !== 9'd0 || req_ready !== 1'b1 || stk_opcode !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: rv=%b data=%h depth=%0d rdy=%b op=%b required 0 00 0 1 0000",
                     rsp_valid, rsp_data, depth, req_ready, stk_opcode);
        end
        model_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) pulses++;
        end
        n_checks++;
        if (pulses != 0 || depth !== 9'd0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_after: pulses=%0d depth=%0d rdy=%b required 0 0 1", pulses, depth, req_ready);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = '0;
        test_reset();
        @(posedge clk); #1;
        test_order();
        test_underflow();
        test_illegal_hold();
        test_random();
        test_overflow();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
